// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle instruction sequencer. Fetches a 53-bit instruction word over a
// request/ack handshake, latches it into the instruction register, then steps
// through decode, register read, ALU execute and write-back. An opcode of 4'hF
// halts the machine. A fetch that is never acknowledged ends in a sticky fault
// that only reset clears.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      level; starts from IDLE, restarts at pc=0 from HALT
//   imem_req    out  1      fetch request, high for every FETCH cycle
//   imem_addr   out  PC_W   fetch address, always equal to pc
//   imem_rdata  in   53     instruction word, sampled only with imem_ack
//   imem_ack    in   1      fetch completion strobe
//   ir          out  53     instruction register
//   rf_rd_en    out  1      register-file read strobe (READ)
//   alu_start   out  1      ALU launch pulse (first EXEC cycle)
//   alu_done    in   1      ALU completion strobe
//   rf_wr_en    out  1      register-file write strobe (WB, gated by ir[15])
//   pc          out  PC_W   program counter
//   busy        out  1      FETCH/DECODE/READ/EXEC/WB
//   halted      out  1      HALT
//   fault       out  1      FAULT
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int PC_W        = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [52:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [52:0]     ir,
  output logic            rf_rd_en,
  output logic            alu_start,
  input  logic            alu_done,
  output logic            rf_wr_en,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            fault
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  // Last wait-count value at which a missing ack still leaves FETCH alive.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [3:0]       OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [52:0]       r_ir;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_imem_req;
  logic              r_rf_rd_en;
  logic              r_alu_start;
  logic              r_rf_wr_en;
  logic              r_busy;
  logic              r_halted;
  logic              r_fault;

  state_t            w_state_nxt;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [52:0]       w_ir_nxt;
  logic [CNT_W-1:0]  w_wait_cnt_nxt;
  logic              w_imem_req_nxt;
  logic              w_rf_rd_en_nxt;
  logic              w_alu_start_nxt;
  logic              w_rf_wr_en_nxt;
  logic              w_busy_nxt;
  logic              w_halted_nxt;
  logic              w_fault_nxt;

  logic [3:0]        w_opcode;
  logic              w_load_imm;

  assign w_opcode   = r_ir[20:17];
  assign w_load_imm = r_ir[16];

  // Next-state, datapath and next-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    // The wait counter only carries a value while stalled in FETCH, so it is
    // automatically zero on every FETCH entry.
    w_wait_cnt_nxt = {CNT_W{1'b0}};

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_FETCH: begin
        // An ack always wins, including on the final allowed wait cycle.
        if (imem_ack) begin
          w_ir_nxt    = imem_rdata;
          w_state_nxt = S_DECODE;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end

      S_DECODE: begin
        if (w_opcode == OP_HALT) begin
          w_state_nxt = S_HALT;
        end else if (w_load_imm) begin
          w_state_nxt = S_WB;
        end else begin
          w_state_nxt = S_READ;
        end
      end

      S_READ: begin
        w_state_nxt = S_EXEC;
      end

      S_EXEC: begin
        // r_alu_start is high exactly in the first EXEC cycle, which is the
        // cycle in which alu_done must be ignored.
        if (!r_alu_start && alu_done) begin
          w_state_nxt = S_WB;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end

      S_WB: begin
        w_pc_nxt    = r_pc + PC_W'(1);
        w_state_nxt = S_FETCH;
      end

      S_HALT: begin
        if (start) begin
          w_pc_nxt    = {PC_W{1'b0}};
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_HALT;
        end
      end

      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs are computed from the next state so that, once registered,
    // they line up with the state they describe.
    w_imem_req_nxt  = (w_state_nxt == S_FETCH);
    w_rf_rd_en_nxt  = (w_state_nxt == S_READ);
    w_alu_start_nxt = (w_state_nxt == S_EXEC) && (r_state != S_EXEC);
    w_rf_wr_en_nxt  = (w_state_nxt == S_WB) && w_ir_nxt[15];
    w_busy_nxt      = (w_state_nxt == S_FETCH) || (w_state_nxt == S_DECODE) ||
                      (w_state_nxt == S_READ)  || (w_state_nxt == S_EXEC)   ||
                      (w_state_nxt == S_WB);
    w_halted_nxt    = (w_state_nxt == S_HALT);
    w_fault_nxt     = (w_state_nxt == S_FAULT);
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= {PC_W{1'b0}};
      r_ir        <= 53'd0;
      r_wait_cnt  <= {CNT_W{1'b0}};
      r_imem_req  <= 1'b0;
      r_rf_rd_en  <= 1'b0;
      r_alu_start <= 1'b0;
      r_rf_wr_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ir        <= w_ir_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_imem_req  <= w_imem_req_nxt;
      r_rf_rd_en  <= w_rf_rd_en_nxt;
      r_alu_start <= w_alu_start_nxt;
      r_rf_wr_en  <= w_rf_wr_en_nxt;
      r_busy      <= w_busy_nxt;
      r_halted    <= w_halted_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign ir        = r_ir;
  assign rf_rd_en  = r_rf_rd_en;
  assign alu_start = r_alu_start;
  assign rf_wr_en  = r_rf_wr_en;
  assign pc        = r_pc;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign fault     = r_fault;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Directed bench for instr_sequencer. Every instruction expected to write back
// is pushed (pc, instruction word) onto a scoreboard when its fetch is
// acknowledged; a negedge monitor pops and compares on each rf_wr_en pulse and
// also counts strobe pulses and checks that strobes never overlap.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int PC_W        = 8;
  localparam int ACK_TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [52:0]     imem_rdata;
  logic            imem_ack;
  logic [52:0]     ir;
  logic            rf_rd_en;
  logic            alu_start;
  logic            alu_done;
  logic            rf_wr_en;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
  logic            fault;

  instr_sequencer #(.PC_W(PC_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .ir(ir), .rf_rd_en(rf_rd_en), .alu_start(alu_start),
    .alu_done(alu_done), .rf_wr_en(rf_wr_en), .pc(pc), .busy(busy),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [52:0]     ir;
  } exp_t;

  exp_t            sb_q[$];
  exp_t            mon_e;
  int              n_checks = 0;
  int              n_errors = 0;
  int              n_rd = 0;
  int              n_alu = 0;
  int              n_wr = 0;
  logic [PC_W-1:0] exp_pc;
  logic [52:0]     w;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [52:0] rnd_word();
    logic [52:0] r;
    r[31:0]  = $urandom;
    r[52:32] = 21'($urandom);
    return r;
  endfunction

  function automatic logic [52:0] mk(input logic [3:0] op, input logic li, input logic rw);
    logic [52:0] r;
    r        = rnd_word();
    r[20:17] = op;
    r[16]    = li;
    r[15]    = rw;
    return r;
  endfunction

  function automatic logic [22:0] ctl();
    return {pc, imem_addr, imem_req, rf_rd_en, alu_start, rf_wr_en, busy, halted, fault};
  endfunction

  // Acknowledge a fetch on the current FETCH cycle; leaves the DUT in DECODE.
  task automatic issue(input logic [52:0] word, input bit expect_wr);
    exp_t e;
    imem_ack   = 1'b1;
    imem_rdata = word;
    if (expect_wr) begin
      e.pc = exp_pc;
      e.ir = word;
      sb_q.push_back(e);
    end
    step();
    imem_ack   = 1'b0;
    imem_rdata = rnd_word();
  endtask

  // Strobe monitor and write-back scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rf_rd_en)  n_rd++;
      if (alu_start) n_alu++;
      if (rf_wr_en)  n_wr++;
      if (rf_rd_en || alu_start || rf_wr_en)
        check("strobe_onehot", 64'($countones({rf_rd_en, alu_start, rf_wr_en}) <= 1), 64'd1);
      if (rf_wr_en) begin
        check("wr_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("wb_pc", 64'(pc), 64'(mon_e.pc));
          check("wb_ir", 64'(ir), 64'(mon_e.ir));
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 53'd0;
    alu_done   = 1'b0;
    exp_pc     = '0;

    // Reset state
    #2;
    check("reset_ir", 64'(ir), 64'd0);
    check("reset_ctl", 64'(ctl()), 64'd0);
    #10 rst_n = 1'b1;
    step();
    check("idle", 64'({busy, imem_req, halted, fault}), 64'd0);

    // ALU instruction, alu_done two cycles after alu_start
    start = 1'b1;
    step();
    start = 1'b0;
    check("fetch_entry", 64'({busy, imem_req, imem_addr}), 64'({1'b1, 1'b1, 8'd0}));
    w = mk(4'h1, 1'b0, 1'b1);
    issue(w, 1'b1);
    check("ir_latch", 64'(ir), 64'(w));
    check("decode", 64'({rf_rd_en, alu_start, rf_wr_en, busy, imem_req}), 64'(5'b00010));
    step();
    check("read", 64'({rf_rd_en, alu_start, rf_wr_en, busy}), 64'(4'b1001));
    step();
    check("exec_first", 64'({rf_rd_en, alu_start, rf_wr_en, busy}), 64'(4'b0101));
    step();
    check("exec_wait1", 64'({rf_rd_en, alu_start, rf_wr_en, busy}), 64'(4'b0001));
    step();
    check("exec_wait2", 64'({rf_rd_en, alu_start, rf_wr_en, busy}), 64'(4'b0001));
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    check("alu_wb", 64'({rf_wr_en, busy, pc}), 64'({1'b1, 1'b1, 8'd0}));
    step();
    exp_pc = exp_pc + 8'd1;
    check("pc_inc", 64'({pc, imem_addr, imem_req, busy}), 64'({exp_pc, exp_pc, 1'b1, 1'b1}));
    check("alu_pulses", 64'({n_rd[7:0], n_alu[7:0], n_wr[7:0]}), 64'(24'h010101));

    // Load-immediate with write: rf_wr_en two cycles after the ack cycle
    w = mk(4'h2, 1'b1, 1'b1);
    issue(w, 1'b1);
    check("li_decode", 64'({rf_rd_en, alu_start, rf_wr_en}), 64'd0);
    step();
    check("li_wb", 64'({rf_rd_en, alu_start, rf_wr_en}), 64'(3'b001));
    step();
    exp_pc = exp_pc + 8'd1;
    check("li_pc", 64'({pc, imem_req}), 64'({exp_pc, 1'b1}));

    // Load-immediate without write
    w = mk(4'h3, 1'b1, 1'b0);
    issue(w, 1'b0);
    step();
    check("li_nowr_wb", 64'({rf_wr_en, busy}), 64'(2'b01));
    step();
    exp_pc = exp_pc + 8'd1;
    check("li_nowr_pc", 64'(pc), 64'(exp_pc));

    // Halt at pc=3 (opcode F beats load_immediate)
    w = mk(4'hF, 1'b1, 1'b1);
    issue(w, 1'b0);
    step();
    check("halt", 64'({halted, busy, imem_req, pc}), 64'({1'b1, 1'b0, 1'b0, 8'd3}));
    imem_ack = 1'b1;
    repeat (3) step();
    imem_ack = 1'b0;
    check("halt_hold", 64'({halted, pc}), 64'({1'b1, 8'd3}));
    check("halt_ir", 64'(ir), 64'(w));
    start = 1'b1;
    step();
    start = 1'b0;
    exp_pc = '0;
    check("restart", 64'({imem_addr, imem_req, halted, busy}), 64'({8'd0, 1'b1, 1'b0, 1'b1}));

    // Ack on the last allowed wait cycle still wins
    repeat (ACK_TIMEOUT - 1) step();
    check("ack_limit_pre", 64'({fault, imem_req}), 64'(2'b01));
    w = mk(4'h0, 1'b1, 1'b0);
    issue(w, 1'b0);
    check("ack_limit_win", 64'({busy, fault, imem_req}), 64'(3'b100));
    step();
    step();
    exp_pc = exp_pc + 8'd1;
    check("ack_limit_pc", 64'(pc), 64'(exp_pc));

    // Timeout: 15 cycles without ack
    repeat (ACK_TIMEOUT - 1) step();
    check("timeout_pre", 64'({fault, imem_req}), 64'(2'b01));
    step();
    check("timeout", 64'({fault, imem_req, busy, halted}), 64'(4'b1000));
    start    = 1'b1;
    imem_ack = 1'b1;
    repeat (4) step();
    start    = 1'b0;
    imem_ack = 1'b0;
    check("fault_sticky", 64'({fault, imem_req, busy, pc}), 64'({1'b1, 1'b0, 1'b0, exp_pc}));
    #2 rst_n = 1'b0;
    #1;
    check("fault_reset", 64'(ctl()), 64'd0);
    step();
    rst_n = 1'b1;
    exp_pc = '0;
    step();
    check("post_fault_idle", 64'({busy, fault, imem_req}), 64'd0);

    // Run up to pc=255 with load-immediate writes, then wrap
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      w = mk(4'($urandom_range(14, 0)), 1'b1, 1'b1);
      issue(w, 1'b1);
      step();
      step();
      exp_pc = exp_pc + 8'd1;
    end
    check("pc_255", 64'({pc, imem_addr}), 64'({8'd255, 8'd255}));
    w = mk(4'h5, 1'b0, 1'b1);
    issue(w, 1'b1);
    step();
    step();
    check("wrap_exec_first", 64'(alu_start), 64'd1);
    alu_done = 1'b1;
    step();
    check("alu_done_ignored_first", 64'({rf_wr_en, busy, alu_start}), 64'(3'b010));
    step();
    alu_done = 1'b0;
    check("wrap_wb", 64'({rf_wr_en, pc}), 64'({1'b1, 8'd255}));
    step();
    exp_pc = exp_pc + 8'd1;
    check("pc_wrap", 64'({pc, imem_addr, imem_req}), 64'({exp_pc, 8'd0, 1'b1}));

    // Reset during EXEC abandons the instruction
    w = mk(4'h6, 1'b0, 1'b1);
    issue(w, 1'b0);
    step();
    step();
    step();
    check("exec_before_reset", 64'({busy, alu_start, rf_wr_en}), 64'(3'b100));
    alu_done = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("exec_reset_ctl", 64'(ctl()), 64'd0);
    check("exec_reset_ir", 64'(ir), 64'd0);
    repeat (3) step();
    #2 rst_n = 1'b1;
    step();
    alu_done = 1'b0;
    step();
    check("exec_reset_idle", 64'(ctl()), 64'd0);

    // Totals
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("wr_count", 64'(n_wr), 64'd258);
    check("rd_count", 64'(n_rd), 64'd3);
    check("alu_count", 64'(n_alu), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PC_W, default 8: program counter and instruction-address width.
REQ-002 Parameter ACK_TIMEOUT, default 15: maximum wait cycles for imem_ack before fault.
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  Reset; asynchronous and active-low.
REQ-005 start  input  1  Level; begins or restarts execution from IDLE or HALT.
REQ-006 imem_req  output  1  Instruction-fetch request, held high until ack or timeout.
REQ-007 imem_addr  output  PC_W  Fetch address; always equals pc.
REQ-008 imem_rdata  input  53  Instruction word; valid only in an imem_ack cycle.
REQ-009 imem_ack  input  1  Fetch completion strobe.
REQ-010 ir  output  53  Latched instruction register; drives the decoder input.
REQ-011 rf_rd_en  output  1  One-cycle register-file read strobe.
REQ-012 alu_start  output  1  One-cycle ALU launch pulse.
REQ-013 alu_done  input  1  ALU completion strobe.
REQ-014 rf_wr_en  output  1  One-cycle register-file write strobe.
REQ-015 pc  output  PC_W  Program counter.
REQ-016 busy  output  1  High in FETCH, DECODE, READ, EXEC and WB.
REQ-017 halted  output  1  High in HALT.
REQ-018 fault  output  1  High in FAULT.

Function
REQ-019 The FSM SHALL have the states IDLE, FETCH, DECODE, READ, EXEC, WB, HALT and FAULT; all outputs are registered or decoded from the state only.
REQ-020 Field map of ir: opcode = ir[20:17]; load_immediate = ir[16]; read_write = ir[15].
REQ-021 IDLE: start=1 -> FETCH on the next edge; otherwise remain in IDLE.
REQ-022 FETCH: imem_req=1; imem_ack=1 -> ir <= imem_rdata, go to DECODE, and clear the wait counter.
REQ-023 FETCH wait counter: increments on each cycle without ack; reaching ACK_TIMEOUT with no ack -> FAULT; an ack on the same cycle as the limit wins.
REQ-024 DECODE (exactly 1 cycle), first match applies: opcode==4'hF -> HALT; load_immediate=1 -> WB; otherwise -> READ.
REQ-025 READ (1 cycle): rf_rd_en=1 -> EXEC.
REQ-026 EXEC: alu_start=1 in the first cycle only; alu_done is ignored in that cycle and sampled from the next cycle on; alu_done=1 -> WB; there is no timeout.
REQ-027 WB (1 cycle): rf_wr_en = ir[15]; pc <= pc+1, wrapping modulo 2^PC_W; -> FETCH.
REQ-028 HALT: pc and ir are held; start=1 -> pc <= 0 and -> FETCH.
REQ-029 FAULT: sticky; only rst_n exits FAULT; start is ignored.
REQ-030 start is ignored in every state except IDLE and HALT.
REQ-031 Latency per instruction, counted from FETCH entry with ack on the first cycle: load-immediate = 3 cycles; ALU op = 5 + (alu_done delay beyond the first EXEC cycle) cycles.
REQ-032 No more than one of rf_rd_en, alu_start and rf_wr_en SHALL be high in any cycle.

Reset
REQ-033 rst_n=0 SHALL immediately force: state=IDLE, pc=0, ir=0, wait counter=0, and all strobes, busy, halted and fault = 0.
REQ-034 Reset asserted mid-instruction SHALL abandon the instruction with no rf_wr_en emitted; release returns the block to IDLE.

Verification
REQ-035 Reset, start=1, ack with rdata {opcode=4'h1, li=0, rw=1} on the first FETCH cycle, alu_done 2 cycles after alu_start -> rf_rd_en, alu_start and rf_wr_en each pulse once; pc goes 0->1; busy stays high throughout.
REQ-036 Instruction with li=1, rw=1 -> no rf_rd_en or alu_start; rf_wr_en is asserted exactly 2 cycles after the ack cycle.
REQ-037 Instruction with opcode=4'hF at pc=3 -> halted=1 and pc=3 held; a later start=1 -> next imem_addr=0.
REQ-038 Withhold imem_ack for 15 cycles -> fault=1 and imem_req=0; start has no effect; only rst_n clears fault.
REQ-039 With PC_W=8 and pc=255, run a non-halt instruction -> pc=0 after WB and the next fetch address is 0.
REQ-040 Assert rst_n=0 during EXEC -> all outputs read 0 asynchronously and no rf_wr_en occurs.
